// File: rtl/traffic_sensor_cond_if.sv
// Signal bundle between the raw sensor side and the conditioning stage.
// There is no handshake: the raw inputs are free-running levels, and the
// conditioned outputs are registered levels/pulses that update on every clock.
// emg_state exposes the emergency FSM state for observation.
interface traffic_sensor_cond_if #(
   parameter int CNT_W = 8
);
   logic             raw_car;
   logic             raw_emerg;
   logic             emerg_clear;
   logic             C;
   logic             Emergency;
   logic             emg_timeout;
   logic [CNT_W-1:0] car_count;
   logic [1:0]       emg_state;

   // Sensor/stimulus side: drives the raw levels, observes the conditioned outputs.
   modport master (
      output raw_car, raw_emerg, emerg_clear,
      input  C, Emergency, emg_timeout, car_count, emg_state
   );

   // Conditioning stage side.
   modport slave (
      input  raw_car, raw_emerg, emerg_clear,
      output C, Emergency, emg_timeout, car_count, emg_state
   );
endinterface

// File: rtl/traffic_sensor_cond.sv
// Input conditioning for the traffic controller: 2-flop synchronisers,
// a debounced vehicle-present level with a saturating event counter, and an
// emergency-request shaper (confirm / min-hold / max-hold / re-arm).
module traffic_sensor_cond #(
   parameter int DEB_CYCLES   = 4,
   parameter int EMG_MIN_HOLD = 16,
   parameter int EMG_MAX_HOLD = 64,
   parameter int CNT_W        = 8
) (
   input logic                  Clk,
   input logic                  reset,
   traffic_sensor_cond_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONFIRM = 2'd1,
      ACTIVE  = 2'd2,
      REARM   = 2'd3
   } emg_state_t;

   // Debounce counter only needs to reach DEB_CYCLES-1; ec must cover both
   // the confirm/re-arm window and the max hold.
   localparam int DW   = $clog2(DEB_CYCLES + 1);
   localparam int EMAX = (EMG_MAX_HOLD > DEB_CYCLES) ? EMG_MAX_HOLD : DEB_CYCLES;
   localparam int EW   = $clog2(EMAX + 1);

   localparam logic [DW-1:0] DEB_LAST_D = DW'(DEB_CYCLES - 1);
   localparam logic [EW-1:0] DEB_LAST_E = EW'(DEB_CYCLES - 1);
   localparam logic [EW-1:0] MIN_LAST   = EW'(EMG_MIN_HOLD - 1);
   localparam logic [EW-1:0] MAX_LAST   = EW'(EMG_MAX_HOLD - 1);

   logic             r_car_s1, r_car_s;
   logic             r_emg_s1, r_emg_s;
   logic [DW-1:0]    r_car_cnt;
   logic             r_c;
   logic [CNT_W-1:0] r_count;

   emg_state_t       r_state, w_next;
   logic [EW-1:0]    r_ec, w_ec;
   logic             r_emergency;
   logic             r_timeout, w_timeout;

   // Two-flop synchronisers on the asynchronous detector inputs.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_car_s1 <= 1'b0;
         r_car_s  <= 1'b0;
         r_emg_s1 <= 1'b0;
         r_emg_s  <= 1'b0;
      end else begin
         r_car_s1 <= bus.raw_car;
         r_car_s  <= r_car_s1;
         r_emg_s1 <= bus.raw_emerg;
         r_emg_s  <= r_emg_s1;
      end
   end

   // Car debouncer: C follows car_s only after DEB_CYCLES consecutive
   // disagreeing samples; rising edges of C feed the saturating counter.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_car_cnt <= '0;
         r_c       <= 1'b0;
         r_count   <= '0;
      end else if (r_car_s != r_c) begin
         if (r_car_cnt == DEB_LAST_D) begin
            r_car_cnt <= '0;
            r_c       <= ~r_c;
            if (!r_c && (r_count != {CNT_W{1'b1}}))
               r_count <= r_count + CNT_W'(1);
         end else begin
            r_car_cnt <= r_car_cnt + DW'(1);
         end
      end else begin
         r_car_cnt <= '0;
      end
   end

   // Emergency FSM next state; forced release is checked before the
   // voluntary release so the timeout wins when both coincide.
   always_comb begin
      w_next    = r_state;
      w_ec      = r_ec;
      w_timeout = 1'b0;
      case (r_state)
         IDLE: begin
            w_ec = '0;
            if (r_emg_s) begin
               if (DEB_CYCLES == 1) begin
                  w_next = ACTIVE;
               end else begin
                  w_next = CONFIRM;
                  w_ec   = EW'(1);
               end
            end
         end
         CONFIRM: begin
            if (!r_emg_s) begin
               w_next = IDLE;
               w_ec   = '0;
            end else if (r_ec == DEB_LAST_E) begin
               w_next = ACTIVE;
               w_ec   = '0;
            end else begin
               w_ec = r_ec + EW'(1);
            end
         end
         ACTIVE: begin
            w_ec = r_ec + EW'(1);
            if (r_ec == MAX_LAST) begin
               w_next    = REARM;
               w_ec      = '0;
               w_timeout = 1'b1;
            end else if ((r_ec >= MIN_LAST) && (!r_emg_s || bus.emerg_clear)) begin
               w_next = r_emg_s ? REARM : IDLE;
               w_ec   = '0;
            end
         end
         REARM: begin
            if (r_emg_s) begin
               w_ec = '0;
            end else if (r_ec == DEB_LAST_E) begin
               w_next = IDLE;
               w_ec   = '0;
            end else begin
               w_ec = r_ec + EW'(1);
            end
         end
         default: begin
            w_next = IDLE;
            w_ec   = '0;
         end
      endcase
   end

   // Emergency FSM state register with registered level and timeout pulse.
   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ec        <= '0;
         r_emergency <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_ec        <= w_ec;
         r_emergency <= (w_next == ACTIVE);
         r_timeout   <= w_timeout;
      end
   end

   assign bus.C           = r_c;
   assign bus.car_count   = r_count;
   assign bus.Emergency   = r_emergency;
   assign bus.emg_timeout = r_timeout;
   assign bus.emg_state   = r_state;

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Bench for traffic_sensor_cond: output edge events are predicted with their
// absolute clock-edge number when stimulus is driven, and matched in order
// by a negedge monitor.
module tb_traffic_sensor_cond;

   localparam int DEB   = 4;
   localparam int MINH  = 16;
   localparam int MAXH  = 64;
   localparam int CNT_W = 8;

   // event kinds
   localparam int K_CR = 1;   // C rise
   localparam int K_CF = 2;   // C fall
   localparam int K_ER = 3;   // Emergency rise
   localparam int K_EF = 4;   // Emergency fall
   localparam int K_TR = 5;   // emg_timeout rise
   localparam int K_TF = 6;   // emg_timeout fall

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd2;
   localparam logic [1:0] S_REARM  = 2'd3;

   logic Clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] exp_q[$];
   logic        prev_c, prev_e, prev_t;

   traffic_sensor_cond_if #(.CNT_W(CNT_W)) bus ();

   traffic_sensor_cond #(
      .DEB_CYCLES  (DEB),
      .EMG_MIN_HOLD(MINH),
      .EMG_MAX_HOLD(MAXH),
      .CNT_W       (CNT_W)
   ) dut (
      .Clk  (Clk),
      .reset(reset),
      .bus  (bus)
   );

   // clock and edge counter
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   always @(posedge Clk) begin
      if (cyc > 20000) begin
         $display("FAIL watchdog: cycle %0d exceeded budget 20000", cyc);
         $fatal(1, "watchdog");
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [31:0] ev(input int kind, input int c);
      return {4'(kind), 28'(c)};
   endfunction

   task automatic expect_ev(input int kind, input int c);
      exp_q.push_back(ev(kind, c));
   endtask

   task automatic observe(input int kind);
      logic [31:0] e;
      if (exp_q.size() == 0) e = 32'hFFFF_FFFF;
      else                   e = exp_q.pop_front();
      check_eq("event", ev(kind, cyc), e);
   endtask

   // monitor: every output edge outside reset must match the next expectation
   always @(negedge Clk) begin
      if (reset) begin
         prev_c = bus.C;
         prev_e = bus.Emergency;
         prev_t = bus.emg_timeout;
      end else begin
         if (bus.C !== prev_c)           observe(bus.C ? K_CR : K_CF);
         if (bus.Emergency !== prev_e)   observe(bus.Emergency ? K_ER : K_EF);
         if (bus.emg_timeout !== prev_t) observe(bus.emg_timeout ? K_TR : K_TF);
         prev_c = bus.C;
         prev_e = bus.Emergency;
         prev_t = bus.emg_timeout;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_C"},     32'(bus.C), 32'd0);
      check_eq({tag, "_E"},     32'(bus.Emergency), 32'd0);
      check_eq({tag, "_tmo"},   32'(bus.emg_timeout), 32'd0);
      check_eq({tag, "_cnt"},   32'(bus.car_count), 32'd0);
      check_eq({tag, "_state"}, 32'(bus.emg_state), 32'(S_IDLE));
   endtask

   task automatic do_reset();
      bus.raw_car     = 1'b0;
      bus.raw_emerg   = 1'b0;
      bus.emerg_clear = 1'b0;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      check_idle_outputs("rst");
   endtask

   // one clean car event: high 8 cycles, low 8 cycles
   task automatic car_event();
      bus.raw_car = 1'b1;
      expect_ev(K_CR, cyc + 2 + DEB);
      tick(8);
      bus.raw_car = 1'b0;
      expect_ev(K_CF, cyc + 2 + DEB);
      tick(8);
   endtask

   initial begin
      int e;
      bus.raw_car     = 1'b0;
      bus.raw_emerg   = 1'b0;
      bus.emerg_clear = 1'b0;
      do_reset();

      // 1: clean car assertion and release
      bus.raw_car = 1'b1;
      expect_ev(K_CR, cyc + 2 + DEB);
      tick(10);
      check_eq("t1_cnt_after_rise", 32'(bus.car_count), 32'd1);
      bus.raw_car = 1'b0;
      expect_ev(K_CF, cyc + 2 + DEB);
      tick(10);
      check_eq("t1_cnt_after_fall", 32'(bus.car_count), 32'd1);

      // 2: glitches shorter than the debounce window
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.raw_car = 1'b1;
         tick(3);
         bus.raw_car = 1'b0;
         tick(3);
      end
      tick(10);
      check_eq("t2_C", 32'(bus.C), 32'd0);
      check_eq("t2_cnt", 32'(bus.car_count), 32'd0);

      // 3: short request held to the minimum hold, then back to IDLE
      bus.raw_emerg = 1'b1;
      e = cyc;
      expect_ev(K_ER, e + 2 + DEB);
      expect_ev(K_EF, e + 2 + DEB + MINH);
      tick(10);
      bus.raw_emerg = 1'b0;
      tick(40);
      check_eq("t3_state", 32'(bus.emg_state), 32'(S_IDLE));

      // 4: stuck request released by the max hold, never re-asserts
      bus.raw_emerg = 1'b1;
      e = cyc;
      expect_ev(K_ER, e + 2 + DEB);
      expect_ev(K_EF, e + 2 + DEB + MAXH);
      expect_ev(K_TR, e + 2 + DEB + MAXH);
      expect_ev(K_TF, e + 3 + DEB + MAXH);
      tick(100);
      check_eq("t4_state_rearm", 32'(bus.emg_state), 32'(S_REARM));
      check_eq("t4_E_low", 32'(bus.Emergency), 32'd0);
      bus.raw_emerg = 1'b0;
      tick(10);
      check_eq("t4_state_idle", 32'(bus.emg_state), 32'(S_IDLE));
      bus.raw_emerg = 1'b1;
      e = cyc;
      expect_ev(K_ER, e + 2 + DEB);
      tick(8);
      bus.raw_emerg = 1'b0;
      expect_ev(K_EF, e + 2 + DEB + MINH);
      tick(40);

      // 5: operator clear ignored before min hold, honoured after
      bus.raw_emerg = 1'b1;
      e = cyc;
      expect_ev(K_ER, e + 2 + DEB);
      tick(2 + DEB + 5);          // hold counter sampled as 5 at next edge
      bus.emerg_clear = 1'b1;
      tick(1);
      bus.emerg_clear = 1'b0;
      check_eq("t5_state_active", 32'(bus.emg_state), 32'(S_ACTIVE));
      check_eq("t5_E_held", 32'(bus.Emergency), 32'd1);
      tick(14);                   // now at edge e+26
      bus.emerg_clear = 1'b1;
      expect_ev(K_EF, cyc + 1);
      tick(1);
      bus.emerg_clear = 1'b0;
      check_eq("t5_state_rearm", 32'(bus.emg_state), 32'(S_REARM));
      check_eq("t5_tmo", 32'(bus.emg_timeout), 32'd0);
      tick(20);
      bus.raw_emerg = 1'b0;
      tick(12);
      check_eq("t5_state_idle", 32'(bus.emg_state), 32'(S_IDLE));

      // 6: counter saturation, then reset mid-ACTIVE with C high
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         car_event();
         if (i == 254 || i == 255 || i == 256 || i == 300)
            check_eq($sformatf("t6_cnt_%0d", i), 32'(bus.car_count), 32'(i > 255 ? 255 : i));
      end
      bus.raw_car   = 1'b1;
      bus.raw_emerg = 1'b1;
      expect_ev(K_CR, cyc + 2 + DEB);
      expect_ev(K_ER, cyc + 2 + DEB);
      tick(15);
      check_eq("t6_E_pre", 32'(bus.Emergency), 32'd1);
      check_eq("t6_C_pre", 32'(bus.C), 32'd1);
      reset = 1'b1;
      tick(1);
      check_idle_outputs("t6_rst");
      bus.raw_car   = 1'b0;
      bus.raw_emerg = 1'b0;
      tick(1);
      reset = 1'b0;
      tick(10);

      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
